data_ram_bridge: RTL and testbench

Converts the single-cycle data-RAM request produced by the load/store unit into a split-transaction SRAM-like bus (request/addr_ok, then data_ok), and stalls the pipeline until the transaction completes. It sits directly downstream of the LSU: it consumes the LSU's `data_ram_*` request in the EX stage and returns `data_ram_rdata` for the LSU's MEM-stage extraction. Read data stays stable for the load while that load is in MEM, including across back-to-back accesses and external stalls.

---
 rtl/data_ram_bridge.sv | 117 +++++++++++
 tb/tb_data_ram_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_bridge.sv
// rtl/data_ram_bridge.sv - single-cycle LSU data-RAM request to split-transaction bus bridge
`timescale 1ns/1ps
module data_ram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ram_en,
    input  logic [3:0]  data_ram_wen,
    input  logic [31:0] data_ram_addr,
    input  logic [31:0] data_ram_wdata,
    output logic [31:0] data_ram_rdata,
    input  logic        pipe_stall,
    input  logic        flush,
    output logic        stall_req,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        cancel_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rbuf_q;
    logic        capture;
    logic [1:0]  size_d;

    always_comb begin
        case (data_ram_wen)
            4'b0001: size_d = 2'd0;
            4'b0011: size_d = 2'd1;
            default: size_d = 2'd2;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A flush coinciding with addr_ok cannot retract the request: it is tracked via cancel_q.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: if (data_ram_en && !flush) begin
                capture   = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                if (data_addr_ok)  state_nxt = WAIT;
                else if (flush)    state_nxt = IDLE;
            end
            WAIT: if (data_data_ok) begin
                if (cancel_q || flush || !pipe_stall) state_nxt = IDLE;
                else                                  state_nxt = DONE;
            end
            DONE: if (flush || !pipe_stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stall_req = (state == IDLE && data_ram_en && !flush)
                     || (state == REQ)
                     || (state == WAIT && !(data_data_ok && !cancel_q))
                     || (state == WAIT && cancel_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cancel_q <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            rbuf_q   <= 32'd0;
        end else begin
            if (capture) begin
                wr_q    <= |data_ram_wen;
                size_q  <= size_d;
                addr_q  <= data_ram_addr;
                wdata_q <= data_ram_wdata;
            end
            case (state)
                REQ: if (data_addr_ok && flush) cancel_q <= 1'b1;
                WAIT: begin
                    if (data_data_ok) begin
                        cancel_q <= 1'b0;
                        if (!cancel_q && !flush && !wr_q) begin
                            if (pipe_stall) rbuf_q  <= data_rdata;
                            else            rdata_q <= data_rdata;
                        end
                    end else if (flush) begin
                        cancel_q <= 1'b1;
                    end
                end
                // Buffered data moves to rdata_q only at the edge the pipeline advances.
                DONE: if (!flush && !pipe_stall && !wr_q) rdata_q <= rbuf_q;
                default: ;
            endcase
        end
    end

    assign data_req       = (state == REQ);
    assign data_wr        = wr_q;
    assign data_size      = size_q;
    assign data_addr      = addr_q;
    assign data_wdata     = wdata_q;
    assign data_ram_rdata = rdata_q;

endmodule

// File: tb/tb_data_ram_bridge.sv
// tb/tb_data_ram_bridge.sv - scoreboard bench for data_ram_bridge
`timescale 1ns/1ps
module tb_data_ram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_ram_en = 1'b0;
    logic [3:0]  data_ram_wen = 4'd0;
    logic [31:0] data_ram_addr = 32'd0;
    logic [31:0] data_ram_wdata = 32'd0;
    logic [31:0] data_ram_rdata;
    logic        pipe_stall = 1'b0;
    logic        flush = 1'b0;
    logic        stall_req;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] last_rd = 32'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    data_ram_bridge dut (
        .clk(clk), .rst(rst),
        .data_ram_en(data_ram_en), .data_ram_wen(data_ram_wen),
        .data_ram_addr(data_ram_addr), .data_ram_wdata(data_ram_wdata),
        .data_ram_rdata(data_ram_rdata),
        .pipe_stall(pipe_stall), .flush(flush), .stall_req(stall_req),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_size(input logic [3:0] wen);
        if (wen == 4'b0001)      return 2'd0;
        else if (wen == 4'b0011) return 2'd1;
        else                     return 2'd2;
    endfunction

    task automatic idle();
        @(negedge clk);
        data_ram_en  = 1'b0;
        data_ram_wen = 4'd0;
    endtask

    task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int ok_dly, input int data_dly, input int hold);
        req_t r;
        int   n_stall;
        @(negedge clk);
        data_ram_en = 1'b1; data_ram_wen = wen; data_ram_addr = addr; data_ram_wdata = wdata;
        r.wr = (wen != 4'd0); r.size = exp_size(wen); r.addr = addr; r.wdata = wdata;
        req_q.push_back(r);
        if (wen == 4'd0) rd_q.push_back(rd);
        n_stall = 0;
        #1 if (stall_req) n_stall++;
        for (int i = 0; i <= ok_dly; i++) begin
            @(negedge clk);
            data_addr_ok = (i == ok_dly);
            #1;
            check("req_valid", data_req, 1);
            check("req_wr", data_wr, req_q[0].wr);
            check("req_size", data_size, req_q[0].size);
            check("req_addr", data_addr, req_q[0].addr);
            check("req_wdata", data_wdata, req_q[0].wdata);
            if (stall_req) n_stall++;
        end
        r = req_q.pop_front();
        for (int i = 0; i <= data_dly; i++) begin
            @(negedge clk);
            data_addr_ok = 1'b0;
            data_data_ok = (i == data_dly);
            data_rdata   = data_data_ok ? rd : $urandom;
            pipe_stall   = data_data_ok && (hold > 0);
            #1;
            check("wait_noreq", data_req, 0);
            check("wait_rdata", data_ram_rdata, last_rd);
            if (stall_req) n_stall++;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            pipe_stall   = (i < hold - 1);
            #1;
            check("done_noreq", data_req, 0);
            check("done_stall", stall_req, 0);
            check("done_rdata", data_ram_rdata, last_rd);
        end
        @(posedge clk);
        #1;
        data_data_ok = 1'b0;
        pipe_stall   = 1'b0;
        if (r.wr == 1'b0) last_rd = rd_q.pop_front();
        check("adv_rdata", data_ram_rdata, last_rd);
        check("stall_cnt", n_stall, 2 + ok_dly + data_dly);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] wen_tab [5];
        wen_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b1111, 4'b0110};

        #1;
        check("rst_req", data_req, 0);
        check("rst_stall", stall_req, 0);
        check("rst_rdata", data_ram_rdata, 0);
        check("rst_wr", data_wr, 0);
        check("rst_size", data_size, 0);
        check("rst_addr", data_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        access(4'b0000, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
        idle();
        access(4'b0001, 32'h104, 32'h5A5A5A5A, 32'h0, 3, 0, 0);
        idle();
        access(4'b0000, 32'h108, 32'h0, 32'h11111111, 0, 0, 0);
        access(4'b0000, 32'h10C, 32'h0, 32'h22222222, 0, 1, 0);
        idle();
        access(4'b0000, 32'h110, 32'h0, 32'hCAFE0000, 0, 0, 2);
        idle();

        // flush while the request is still pending: nothing is issued
        @(negedge clk);
        data_ram_en = 1'b1; data_ram_wen = 4'b0000; data_ram_addr = 32'h200;
        @(negedge clk);
        flush = 1'b1;
        #1 check("fr_req", data_req, 1);
        @(negedge clk);
        flush = 1'b0; data_ram_en = 1'b0;
        #1;
        check("fr_idle_req", data_req, 0);
        check("fr_idle_stall", stall_req, 0);
        check("fr_rdata", data_ram_rdata, last_rd);

        // flush after acceptance: stall holds until data_ok, data discarded
        @(negedge clk);
        data_ram_en = 1'b1; data_ram_wen = 4'b0000; data_ram_addr = 32'h204;
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0; flush = 1'b1; data_ram_en = 1'b0;
        #1 check("fw_stall_flush", stall_req, 1);
        @(negedge clk);
        flush = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
        #1 check("fw_stall_dataok", stall_req, 1);
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        check("fw_rdata", data_ram_rdata, last_rd);
        check("fw_idle_req", data_req, 0);
        check("fw_idle_stall", stall_req, 0);

        // reset while waiting for data_ok
        @(negedge clk);
        data_ram_en = 1'b1; data_ram_wen = 4'b0000; data_ram_addr = 32'h300;
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1 check("rw_stall_pre", stall_req, 1);
        #1;
        rst = 1'b1; data_ram_en = 1'b0;
        #1;
        check("rw_req", data_req, 0);
        check("rw_stall", stall_req, 0);
        check("rw_rdata", data_ram_rdata, 0);
        check("rw_addr", data_addr, 0);
        check("rw_size", data_size, 0);
        last_rd = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        access(4'b0000, 32'h400, 32'h0, 32'h13572468, 1, 0, 0);

        for (int i = 0; i < 8; i++) begin
            access(wen_tab[$urandom_range(0, 4)], $urandom & 32'hFFFFFFFC, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        idle();
        @(negedge clk);
        #1 check("final_stall", stall_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
